// File: rtl/serial_add_sequencer_if.sv
// Operand, adder and result signals of serial_add_sequencer, bundled.
// master = sequencer side, slave = environment (operand source, adder, result sink).
interface serial_add_sequencer_if;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_a;
  logic [3:0] in_b;
  logic       add_load;
  logic       add_start;
  logic [3:0] add_a;
  logic [3:0] add_b;
  logic [3:0] add_sum;
  logic       add_done;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_sum;
  logic       out_err;

  modport master (
    input  in_valid, in_a, in_b, add_sum, add_done, out_ready,
    output in_ready, add_load, add_start, add_a, add_b, out_valid, out_sum, out_err
  );

  modport slave (
    output in_valid, in_a, in_b, add_sum, add_done, out_ready,
    input  in_ready, add_load, add_start, add_a, add_b, out_valid, out_sum, out_err
  );
endinterface

// File: rtl/serial_add_sequencer.sv
// Operand FIFO + issue/wait/result sequencer in front of the 4-bit bit-serial adder.
// Optional WAIT timeout is enabled with the SEQ_TIMEOUT_EN macro.
module serial_add_sequencer #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TIMEOUT    = 15
) (
  input logic                    clk,
  input logic                    rst_n,
  serial_add_sequencer_if.master bus
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ISSUE  = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_RESULT = 2'd3;

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two >= 2");
  end
  if (TIMEOUT < 8) begin : g_bad_timeout
    $error("TIMEOUT must be >= 8");
  end

  logic [1:0]    state;
  logic [3:0]    mem_a [FIFO_DEPTH];
  logic [3:0]    mem_b [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic [3:0]    op_a;
  logic [3:0]    op_b;
  logic          out_valid_q;
  logic [3:0]    out_sum_q;

  assign full  = (count == (AW+1)'(FIFO_DEPTH));
  assign empty = (count == '0);
  assign push  = bus.in_valid && !full;
  assign pop   = (state == S_IDLE) && !empty;

  assign bus.in_ready  = !full;
  assign bus.add_load  = (state == S_ISSUE);
  assign bus.add_start = (state == S_ISSUE);
  assign bus.add_a     = op_a;
  assign bus.add_b     = op_b;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = out_sum_q;

  // Storage has no reset: count/pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr] <= bus.in_a;
      mem_b[wr_ptr] <= bus.in_b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef SEQ_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] wait_cnt;
  logic          out_err_q;
  assign bus.out_err = out_err_q;
`else
  assign bus.out_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      op_a        <= '0;
      op_b        <= '0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
`ifdef SEQ_TIMEOUT_EN
      wait_cnt    <= '0;
      out_err_q   <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (!empty) begin
            op_a  <= mem_a[rd_ptr];
            op_b  <= mem_b[rd_ptr];
            state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
`ifdef SEQ_TIMEOUT_EN
          wait_cnt <= '0;
`endif
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.add_done) begin
            out_sum_q   <= bus.add_sum;
            out_valid_q <= 1'b1;
`ifdef SEQ_TIMEOUT_EN
            out_err_q   <= 1'b0;
`endif
            state       <= S_RESULT;
          end
`ifdef SEQ_TIMEOUT_EN
          // Compare against TIMEOUT-1 so the abort lands on the edge ending the TIMEOUT-th WAIT cycle.
          else if (wait_cnt == CW'(TIMEOUT - 1)) begin
            out_sum_q   <= '0;
            out_valid_q <= 1'b1;
            out_err_q   <= 1'b1;
            state       <= S_RESULT;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        S_RESULT: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
